bus_share_arbiter: RTL and testbench

- Shares one 32-bit output channel between two requesters (port 0, port 1) with valid/ready handshakes.
- Round-robin arbitration at packet granularity: the grant is held from the first beat to the beat flagged last.
- Drives the select of the 32-bit 2:1 data mux and registers the chosen beat into a one-entry output stage.
- Sits between two producers (e.g. ALU result path and memory read path) and the shared writeback/bus consumer.

---
 rtl/bus_share_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_bus_share_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_share_arbiter.sv
// bus_share_arbiter
// Two-port, packet-granular round-robin arbiter feeding one registered 32-bit
// output stage. The grant is taken on the first accepted beat of a packet and
// held until the beat flagged last is accepted, so beats of different packets
// never interleave on the output.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   req{0,1}_valid/data/last requester beat (held stable until accepted)
//   req{0,1}_ready           beat accepted this cycle
//   out_valid/data/last      registered output beat
//   out_ready                consumer takes the output beat this cycle
//   mux_sel                  data mux select (0 = port 0, 1 = port 1)
//   busy                     a packet is in flight or the output stage is full
//   pkt_cnt{0,1}             saturating per-port packet counters
//
// Optional feature: define ARB_STATS_EN to add pkt_cnt0/pkt_cnt1.

module bus_share_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STATS_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_data,
  input  logic               req0_last,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_data,
  input  logic               req1_last,
  output logic               req1_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic               mux_sel,
  output logic               busy
`ifdef ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] pkt_cnt0,
  output logic [STATS_W-1:0] pkt_cnt1
`endif
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic             r_last_owner;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;

  logic             w_can_accept;
  logic             w_winner;
  logic             w_sel;
  logic             w_ready0;
  logic             w_ready1;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_last;

  // Output stage can take a beat when empty or being drained this cycle.
  assign w_can_accept = !r_out_valid || out_ready;

  // Idle tie-break: a lone requester wins; on a tie the port that did not
  // finish the previous packet wins.
  always_comb begin
    w_winner = 1'b0;
    if (req0_valid && !req1_valid) begin
      w_winner = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      w_winner = 1'b1;
    end else if (req0_valid && req1_valid) begin
      w_winner = !r_last_owner;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: output decode (mux select and readies)
  always_comb begin
    w_sel    = 1'b0;
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_sel = w_winner;
        if (req0_valid || req1_valid) begin
          if (w_winner) w_ready1 = w_can_accept;
          else          w_ready0 = w_can_accept;
        end
      end
      StOwn0: begin
        w_sel    = 1'b0;
        w_ready0 = w_can_accept;
      end
      StOwn1: begin
        w_sel    = 1'b1;
        w_ready1 = w_can_accept;
      end
      default: begin
        w_sel = 1'b0;
      end
    endcase
  end

  assign w_accept   = (w_ready0 && req0_valid) || (w_ready1 && req1_valid);
  assign w_sel_data = w_sel ? req1_data : req0_data;
  assign w_sel_last = w_sel ? req1_last : req0_last;

  // FSM: next-state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept && !w_sel_last) w_state_next = w_sel ? StOwn1 : StOwn0;
      end
      StOwn0, StOwn1: begin
        if (w_accept && w_sel_last) w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Round-robin history: updated when a packet completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= 1'b1;
    end else if (w_accept && w_sel_last) begin
      r_last_owner <= w_sel;
    end
  end

  // One-entry output stage; a load wins over a drain so throughput stays 1/cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign mux_sel    = w_sel;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign busy       = (r_state != StIdle) || r_out_valid;

`ifdef ARB_STATS_EN
  logic [STATS_W-1:0] r_cnt0;
  logic [STATS_W-1:0] r_cnt1;
  logic [STATS_W-1:0] w_one;

  assign w_one = {{(STATS_W-1){1'b0}}, 1'b1};

  // Saturating packet counters, bumped on each accepted last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_accept && w_sel_last) begin
      if (!w_sel && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + w_one;
      if (w_sel && (r_cnt1 != '1))  r_cnt1 <= r_cnt1 + w_one;
    end
  end

  assign pkt_cnt0 = r_cnt0;
  assign pkt_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_bus_share_arbiter.sv
// tb_bus_share_arbiter
// Directed-vector bench for bus_share_arbiter. Inputs change 1 time unit after
// the rising edge; combinational outputs are checked before the next edge and
// registered outputs 1 unit after it. Stats checks compile in with ARB_STATS_EN.

module tb_bus_share_arbiter;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_last;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_last;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;
  logic             mux_sel;
  logic             busy;

  int n_vec;
  int n_err;

`ifdef ARB_STATS_EN
  logic [15:0]      pkt_cnt0;
  logic [15:0]      pkt_cnt1;
  logic             s_req0_ready;
  logic             s_req1_ready;
  logic             s_out_valid;
  logic [WIDTH-1:0] s_out_data;
  logic             s_out_last;
  logic             s_mux_sel;
  logic             s_busy;
  logic [1:0]       s_cnt0;
  logic [1:0]       s_cnt1;
`endif

  bus_share_arbiter #(
    .WIDTH   (WIDTH),
    .STATS_W (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .mux_sel    (mux_sel),
    .busy       (busy)
`ifdef ARB_STATS_EN
    ,
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1)
`endif
  );

`ifdef ARB_STATS_EN
  // Narrow-counter instance to exercise saturation.
  bus_share_arbiter #(
    .WIDTH   (WIDTH),
    .STATS_W (2)
  ) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (s_req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (s_req1_ready),
    .out_valid  (s_out_valid),
    .out_data   (s_out_data),
    .out_last   (s_out_last),
    .out_ready  (out_ready),
    .mux_sel    (s_mux_sel),
    .busy       (s_busy),
    .pkt_cnt0   (s_cnt0),
    .pkt_cnt1   (s_cnt1)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [31:0] d0, input logic l0,
                       input logic v1, input logic [31:0] d1, input logic l1);
    req0_valid = v0;
    req0_data  = d0;
    req0_last  = l0;
    req1_valid = v1;
    req1_data  = d1;
    req1_last  = l1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Reset state
    #12;
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_out_last", {31'b0, out_last}, 32'd0);
    check_eq("rst_ready0", {31'b0, req0_ready}, 32'd0);
    check_eq("rst_ready1", {31'b0, req1_ready}, 32'd0);
    check_eq("rst_mux_sel", {31'b0, mux_sel}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single-beat packets from both ports alternate, port 0 first.
    out_ready = 1'b1;
    drive(1'b1, 32'hAAAA0000, 1'b1, 1'b1, 32'h5555FFFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("alt_mux_sel", {31'b0, mux_sel}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check_eq("alt_ready0", {31'b0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("alt_ready1", {31'b0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check_eq("alt_out_data", out_data, (i % 2 == 0) ? 32'hAAAA0000 : 32'h5555FFFF);
      check_eq("alt_out_valid", {31'b0, out_valid}, 32'd1);
    end

    // Port 0 three-beat packet locks out port 1.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, i, (i == 3), 1'b1, 32'h5555FFFF, 1'b1);
      #1;
      check_eq("pkt_ready1_blocked", {31'b0, req1_ready}, 32'd0);
      check_eq("pkt_ready0", {31'b0, req0_ready}, 32'd1);
      tick();
      check_eq("pkt_out_data", out_data, i);
      check_eq("pkt_out_last", {31'b0, out_last}, (i == 3) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h5555FFFF, 1'b1);
    #1;
    check_eq("pkt_p1_ready", {31'b0, req1_ready}, 32'd1);
    tick();
    check_eq("pkt_p1_out", out_data, 32'h5555FFFF);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check_eq("drain_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("drain_busy", {31'b0, busy}, 32'd0);

    // Backpressure: beat held while out_ready=0, reload on the drain cycle.
    out_ready = 1'b0;
    drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check_eq("bp_load", out_data, 32'hDEADBEEF);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("bp_ready0", {31'b0, req0_ready}, 32'd0);
      check_eq("bp_ready1", {31'b0, req1_ready}, 32'd0);
      tick();
      check_eq("bp_hold_data", out_data, 32'hDEADBEEF);
      check_eq("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready1", {31'b0, req1_ready}, 32'd1);
    tick();
    check_eq("bp_reload_data", out_data, 32'h12345678);
    check_eq("bp_reload_valid", {31'b0, out_valid}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check_eq("bp_empty", {31'b0, out_valid}, 32'd0);

    // Owner gap: port 1 owns, drops valid for two cycles, port 0 waits.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h11, 1'b0);
    tick();
    check_eq("gap_first", out_data, 32'h11);
    drive(1'b1, 32'h22, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("gap_ready0", {31'b0, req0_ready}, 32'd0);
      check_eq("gap_mux_sel", {31'b0, mux_sel}, 32'd1);
      tick();
      check_eq("gap_out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("gap_busy", {31'b0, busy}, 32'd1);
    end
    drive(1'b1, 32'h22, 1'b1, 1'b1, 32'h33, 1'b1);
    #1;
    check_eq("gap_end_ready0", {31'b0, req0_ready}, 32'd0);
    tick();
    check_eq("gap_end_data", out_data, 32'h33);
    check_eq("gap_end_last", {31'b0, out_last}, 32'd1);
    drive(1'b1, 32'h22, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq("gap_p0_mux", {31'b0, mux_sel}, 32'd0);
    tick();
    check_eq("gap_p0_data", out_data, 32'h22);

    // Asynchronous reset mid-packet.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h44, 1'b0);
    tick();
    check_eq("mid_loaded", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("arst_busy", {31'b0, busy}, 32'd0);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 32'hA0, 1'b1, 1'b1, 32'hB0, 1'b1);
    #1;
    check_eq("arst_tie_mux", {31'b0, mux_sel}, 32'd0);
    check_eq("arst_tie_ready0", {31'b0, req0_ready}, 32'd1);
    tick();
    check_eq("arst_tie_data", out_data, 32'hA0);

    // Packet counters: 5 packets on port 0, 2 on port 1, from a fresh reset.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    drive(1'b1, 32'h50, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (5) tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h60, 1'b1);
    repeat (2) tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check_eq("stats_last_data", out_data, 32'h60);
`ifdef ARB_STATS_EN
    check_eq("stats_cnt0", {16'b0, pkt_cnt0}, 32'd5);
    check_eq("stats_cnt1", {16'b0, pkt_cnt1}, 32'd2);
    check_eq("stats_sat_cnt0", {30'b0, s_cnt0}, 32'd3);
    check_eq("stats_sat_cnt1", {30'b0, s_cnt1}, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog: the stimulus is fixed-length, so this only trips on a stuck run.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
